decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I decode stage: instructions are decoded on entry and held in a small
// circular buffer so fetch and dispatch can stall independently.
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int OPW   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush_i,
  input  logic                       fetchValid_i,
  output logic                       fetchReady_o,
  input  logic [XLEN-1:0]            fetchData_i,
  input  logic [XLEN-1:0]            fetchPc_i,
  output logic                       decValid_o,
  input  logic                       decReady_i,
  output logic [4:0]                 r1Addr_o,
  output logic [4:0]                 r2Addr_o,
  output logic [4:0]                 rdAddr_o,
  output logic [OPW-1:0]             opCode_o,
  output logic [XLEN-1:0]            Imm_o,
  output logic [XLEN-1:0]            Pc_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Internal opcode numbering; 0 is reserved for NOP / illegal.
  localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
  localparam logic [OPW-1:0] OP_JALR  = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(7);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(8);
  localparam logic [OPW-1:0] OP_BLTU  = OPW'(9);
  localparam logic [OPW-1:0] OP_BGEU  = OPW'(10);
  localparam logic [OPW-1:0] OP_LB    = OPW'(11);
  localparam logic [OPW-1:0] OP_LH    = OPW'(12);
  localparam logic [OPW-1:0] OP_LW    = OPW'(13);
  localparam logic [OPW-1:0] OP_LBU   = OPW'(14);
  localparam logic [OPW-1:0] OP_LHU   = OPW'(15);
  localparam logic [OPW-1:0] OP_SB    = OPW'(16);
  localparam logic [OPW-1:0] OP_SH    = OPW'(17);
  localparam logic [OPW-1:0] OP_SW    = OPW'(18);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(19);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(20);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(21);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(22);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(23);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(24);
  localparam logic [OPW-1:0] OP_SLLI  = OPW'(25);
  localparam logic [OPW-1:0] OP_SRLI  = OPW'(26);
  localparam logic [OPW-1:0] OP_SRAI  = OPW'(27);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(28);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(29);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(30);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(31);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(32);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(33);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(34);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(35);
  localparam logic [OPW-1:0] OP_OR    = OPW'(36);
  localparam logic [OPW-1:0] OP_AND   = OPW'(37);

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]      r1;
    logic [4:0]      r2;
    logic [4:0]      rd;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head_e;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        [XLEN-1:0] shamt;

  assign imm_i = XLEN'($signed(fetchData_i[31:20]));
  assign imm_s = XLEN'($signed({fetchData_i[31:25], fetchData_i[11:7]}));
  assign imm_b = XLEN'($signed({fetchData_i[31], fetchData_i[7], fetchData_i[30:25],
                                fetchData_i[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({fetchData_i[31], fetchData_i[19:12], fetchData_i[20],
                                fetchData_i[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({fetchData_i[31:12], 12'b0}));
  assign shamt = XLEN'(fetchData_i[24:20]);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            ill;
  logic            use_r1, use_r2, use_rd;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] imm;

  always_comb begin
    opc    = fetchData_i[6:0];
    f3     = fetchData_i[14:12];
    f7     = fetchData_i[31:25];
    ill    = 1'b0;
    use_r1 = 1'b0;
    use_r2 = 1'b0;
    use_rd = 1'b0;
    op     = '0;
    imm    = '0;
    case (opc)
      7'b0110111: begin op = OP_LUI;   use_rd = 1'b1; imm = imm_u; end
      7'b0010111: begin op = OP_AUIPC; use_rd = 1'b1; imm = imm_u; end
      7'b1101111: begin op = OP_JAL;   use_rd = 1'b1; imm = imm_j; end
      7'b1100111: begin op = OP_JALR;  use_r1 = 1'b1; use_rd = 1'b1; imm = imm_i; end
      7'b1100011: begin
        use_r1 = 1'b1; use_r2 = 1'b1; imm = imm_b;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        use_r1 = 1'b1; use_rd = 1'b1; imm = imm_i;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        use_r1 = 1'b1; use_r2 = 1'b1; imm = imm_s;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        use_r1 = 1'b1; use_rd = 1'b1; imm = imm_i;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            imm = shamt;
            if (f7 == F7_ZERO) op = OP_SLLI;
            else               ill = 1'b1;
          end
          default: begin
            imm = shamt;
            if      (f7 == F7_ZERO) op = OP_SRLI;
            else if (f7 == F7_ALT)  op = OP_SRAI;
            else                    ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        use_r1 = 1'b1; use_r2 = 1'b1; use_rd = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate funct7; everything else needs zero.
        case (f3)
          3'b000: begin
            if      (f7 == F7_ZERO) op = OP_ADD;
            else if (f7 == F7_ALT)  op = OP_SUB;
            else                    ill = 1'b1;
          end
          3'b101: begin
            if      (f7 == F7_ZERO) op = OP_SRL;
            else if (f7 == F7_ALT)  op = OP_SRA;
            else                    ill = 1'b1;
          end
          default: begin
            if (f7 != F7_ZERO) ill = 1'b1;
            case (f3)
              3'b001:  op = OP_SLL;
              3'b010:  op = OP_SLT;
              3'b011:  op = OP_SLTU;
              3'b100:  op = OP_XOR;
              3'b110:  op = OP_OR;
              default: op = OP_AND;
            endcase
          end
        endcase
      end
      default: ill = 1'b1;
    endcase

    dec    = '0;
    dec.pc = fetchPc_i;
    if (ill) begin
      dec.ill = 1'b1;
    end else begin
      dec.op  = op;
      dec.imm = imm;
      dec.r1  = use_r1 ? fetchData_i[19:15] : 5'd0;
      dec.r2  = use_r2 ? fetchData_i[24:20] : 5'd0;
      dec.rd  = use_rd ? fetchData_i[11:7]  : 5'd0;
    end
  end

  assign fetchReady_o = (count < CW'(DEPTH));
  assign decValid_o   = (count != '0);
  assign push = rdy & fetchValid_i & fetchReady_o & ~flush_i;
  assign pop  = rdy & decValid_o & decReady_i & ~flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: the head view is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= dec;
  end

  assign head_e    = decValid_o ? mem[head] : '0;
  assign r1Addr_o  = head_e.r1;
  assign r2Addr_o  = head_e.r2;
  assign rdAddr_o  = head_e.rd;
  assign opCode_o  = head_e.op;
  assign Imm_o     = head_e.imm;
  assign Pc_o      = head_e.pc;
  assign illegal_o = head_e.ill;
  assign count_o   = count;

endmodule

// File: tb/tb_decode_queue.sv
// Table-driven bench for decode_queue: a queue of table indices tracks which
// entries the queue should hold, and the head is compared against the table.
module tb_decode_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int OPW   = 6;

  localparam logic [5:0] LUI = 6'd1, JAL = 6'd3, BEQ = 6'd5, LW = 6'd13, SW = 6'd18;
  localparam logic [5:0] ADDI = 6'd19, SRAI = 6'd27, SRL = 6'd34, SRA = 6'd35;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rdy = 1'b1;
  logic            flush_i = 1'b0;
  logic            fetchValid_i = 1'b0;
  logic            fetchReady_o;
  logic [XLEN-1:0] fetchData_i = '0;
  logic [XLEN-1:0] fetchPc_i = '0;
  logic            decValid_o;
  logic            decReady_i = 1'b0;
  logic [4:0]      r1Addr_o, r2Addr_o, rdAddr_o;
  logic [OPW-1:0]  opCode_o;
  logic [XLEN-1:0] Imm_o, Pc_o;
  logic            illegal_o;
  logic [$clog2(DEPTH):0] count_o;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .fetchValid_i(fetchValid_i), .fetchReady_o(fetchReady_o),
    .fetchData_i(fetchData_i), .fetchPc_i(fetchPc_i),
    .decValid_o(decValid_o), .decReady_i(decReady_i),
    .r1Addr_o(r1Addr_o), .r2Addr_o(r2Addr_o), .rdAddr_o(rdAddr_o),
    .opCode_o(opCode_o), .Imm_o(Imm_o), .Pc_o(Pc_o),
    .illegal_o(illegal_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  op;
    logic [4:0]  r1, r2, rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  int   sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [31:0] inst, input logic [5:0] op,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic ill);
    vec_t v;
    v.inst = inst; v.op = op; v.r1 = r1; v.r2 = r2; v.rd = rd; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] pc_of(input int i);
    return 32'h100 + 32'(4 * i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit fv, input int vi, input bit dr, input bit fl);
    int   n;
    vec_t hd;
    n = sb.size();
    chk("count", 32'(count_o), 32'(n));
    chk("fetch_ready", 32'(fetchReady_o), 32'(n < DEPTH));
    chk("dec_valid", 32'(decValid_o), 32'(n != 0));
    if (n != 0) begin
      hd = tbl[sb[0]];
      chk("opcode", 32'(opCode_o), 32'(hd.op));
      chk("r1", 32'(r1Addr_o), 32'(hd.r1));
      chk("r2", 32'(r2Addr_o), 32'(hd.r2));
      chk("rd", 32'(rdAddr_o), 32'(hd.rd));
      chk("imm", Imm_o, hd.imm);
      chk("pc", Pc_o, pc_of(sb[0]));
      chk("illegal", 32'(illegal_o), 32'(hd.ill));
    end
    fetchValid_i = fv;
    fetchData_i  = tbl[vi].inst;
    fetchPc_i    = pc_of(vi);
    decReady_i   = dr;
    flush_i      = fl;
    @(posedge clk);
    if (rdy) begin
      if (fl) sb.delete();
      else begin
        if (dr && n != 0) void'(sb.pop_front());
        if (fv && n < DEPTH) sb.push_back(vi);
      end
    end
    @(negedge clk);
    fetchValid_i = 1'b0;
    decReady_i   = 1'b0;
    flush_i      = 1'b0;
  endtask

  initial begin
    tbl.push_back(mk(32'h00500093, ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0));
    tbl.push_back(mk(32'h40315233, SRA,  5'd2, 5'd3, 5'd4, 32'd0, 1'b0));
    tbl.push_back(mk(32'h00315233, SRL,  5'd2, 5'd3, 5'd4, 32'd0, 1'b0));
    tbl.push_back(mk(32'hFE000EE3, BEQ,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
    tbl.push_back(mk(32'hFFFFFFFF, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h0000700F, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h0020A423, SW,   5'd1, 5'd2, 5'd0, 32'd8, 1'b0));
    tbl.push_back(mk(32'h123452B7, LUI,  5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0));
    tbl.push_back(mk(32'h40725193, SRAI, 5'd4, 5'd0, 5'd3, 32'd7, 1'b0));
    tbl.push_back(mk(32'hFFC3A303, LW,   5'd7, 5'd0, 5'd6, 32'hFFFFFFFC, 1'b0));
    tbl.push_back(mk(32'h008000EF, JAL,  5'd0, 5'd0, 5'd1, 32'd8, 1'b0));
    tbl.push_back(mk(32'h40001013, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h00002063, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h00003003, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h00004023, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    tbl.push_back(mk(32'h02000033, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_dec_valid", 32'(decValid_o), 32'd0);
    chk("rst_fetch_ready", 32'(fetchReady_o), 32'd1);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_opcode", 32'(opCode_o), 32'd0);
    chk("rst_imm", Imm_o, 32'd0);
    chk("rst_pc", Pc_o, 32'd0);
    chk("rst_rd", 32'(rdAddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single push then pop for every table entry.
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, i, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    step(1'b0, 0, 1'b0, 1'b0);

    // Two illegal entries held back to back.
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Fill, refused third push, then drain with fetch still offering.
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    step(1'b1, 6, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    // rdy low freezes everything, even a flush.
    step(1'b1, 6, 1'b0, 1'b0);
    rdy = 1'b0;
    step(1'b1, 7, 1'b1, 1'b1);
    rdy = 1'b1;
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    // Flush from full with a push offered in the same cycle.
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset between edges while holding entries.
    step(1'b1, 8, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_dec_valid", 32'(decValid_o), 32'd0);
    chk("async_count", 32'(count_o), 32'd0);
    chk("async_fetch_ready", 32'(fetchReady_o), 32'd1);
    chk("async_illegal", 32'(illegal_o), 32'd0);
    sb.delete();
    #1 rst = 1'b1;
    @(negedge clk);
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
